// File: rtl/cache_assoc_wb_pkg.sv
// cache_assoc_wb_pkg: miss-FSM state encoding and parameter sanity helper shared by the cache.
package cache_assoc_wb_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND} state_t;
  function automatic bit is_pow2(input int v);
    return v > 0 && (v & (v - 1)) == 0;
  endfunction
endpackage

// File: rtl/cache_assoc_wb_lru.sv
// cache_assoc_wb_lru: true-LRU for one set; picks the victim and ages the set after touching a way.
module cache_assoc_wb_lru #(
  parameter int NWAYS = 4,
  parameter int AW    = $clog2(NWAYS)
) (
  input  logic [NWAYS-1:0][AW-1:0] i_age,
  input  logic [NWAYS-1:0]         i_valid,
  input  logic [AW-1:0]            i_way,
  output logic [AW-1:0]            o_victim,
  output logic [NWAYS-1:0][AW-1:0] o_age
);
  // an invalid way always beats the oldest way; the lowest-index invalid way wins
  always_comb begin
    o_victim = '0;
    for (int w = 0; w < NWAYS; w++)
      if (i_age[w] == AW'(NWAYS - 1)) o_victim = AW'(w);
    for (int w = NWAYS - 1; w >= 0; w--)
      if (!i_valid[w]) o_victim = AW'(w);
  end
  always_comb begin
    o_age = i_age;
    for (int w = 0; w < NWAYS; w++)
      o_age[w] = (AW'(w) == i_way) ? '0 : (i_age[w] < i_age[i_way]) ? i_age[w] + AW'(1) : i_age[w];
  end
endmodule

// File: rtl/cache_assoc_wb.sv
// cache_assoc_wb: N-way set-associative write-back/write-allocate data cache with true-LRU replacement.
module cache_assoc_wb
  import cache_assoc_wb_pkg::*;
#(
  parameter int PA_WIDTH      = 32,
  parameter int WRD_WIDTH     = 32,
  parameter int NWAYS         = 4,
  parameter int NSETS         = 128,
  parameter int WORDS_PER_BLK = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cpu_req_valid,
  output logic                               cpu_req_ready,
  input  logic                               cpu_req_wr,
  input  logic [PA_WIDTH-1:0]                cpu_req_addr,
  input  logic [WRD_WIDTH-1:0]               cpu_req_wdata,
  input  logic [WRD_WIDTH/8-1:0]             cpu_req_be,
  output logic                               cpu_resp_valid,
  output logic [WRD_WIDTH-1:0]               cpu_resp_rdata,
  output logic                               cpu_resp_hit,
  output logic                               mem_req_valid,
  output logic                               mem_req_wr,
  output logic [PA_WIDTH-1:0]                mem_req_addr,
  output logic [WRD_WIDTH*WORDS_PER_BLK-1:0] mem_req_wblk,
  input  logic                               mem_ack,
  input  logic [WRD_WIDTH*WORDS_PER_BLK-1:0] mem_rd_blk
);
  localparam int BLK_WIDTH = WRD_WIDTH * WORDS_PER_BLK;
  localparam int NBE       = WRD_WIDTH / 8;
  localparam int BO_WIDTH  = $clog2(NBE);
  localparam int WO_WIDTH  = $clog2(WORDS_PER_BLK);
  localparam int IDX_WIDTH = $clog2(NSETS);
  localparam int TAG_WIDTH = PA_WIDTH - IDX_WIDTH - WO_WIDTH - BO_WIDTH;
  localparam int AGE_WIDTH = $clog2(NWAYS);

  if (!is_pow2(NWAYS) || NWAYS < 2 || !is_pow2(NSETS) || !is_pow2(WORDS_PER_BLK)) begin : g_bad_params
    $error("cache_assoc_wb: NWAYS (>=2), NSETS and WORDS_PER_BLK must be powers of 2");
  end

  state_t r_state, w_next;
  logic [PA_WIDTH-1:0]  r_addr;
  logic                 r_wr;
  logic [WRD_WIDTH-1:0] r_wdata;
  logic [NBE-1:0]       r_be;
  logic [AGE_WIDTH-1:0] r_way;
  logic                 r_hit;
  logic [WRD_WIDTH-1:0] r_rdata;
  logic [TAG_WIDTH-1:0] r_tag  [NSETS][NWAYS];
  logic [BLK_WIDTH-1:0] r_data [NSETS][NWAYS];
  logic [NWAYS-1:0]     r_valid [NSETS];
  logic [NWAYS-1:0]     r_dirty [NSETS];
  logic [NWAYS-1:0][AGE_WIDTH-1:0] r_age [NSETS];

  logic [IDX_WIDTH-1:0] w_idx;
  logic [TAG_WIDTH-1:0] w_tag;
  logic [WO_WIDTH-1:0]  w_wo;
  logic                 w_hit;
  logic [AGE_WIDTH-1:0] w_hit_way, w_way, w_victim;
  logic                 w_victim_dirty;
  logic [BLK_WIDTH-1:0] w_blk, w_blk_new;
  logic [WRD_WIDTH-1:0] w_word_old, w_word_new;
  logic [NWAYS-1:0][AGE_WIDTH-1:0] w_age_new;
  logic                 w_unused;

  assign w_idx    = r_addr[BO_WIDTH+WO_WIDTH +: IDX_WIDTH];
  assign w_tag    = r_addr[PA_WIDTH-1 -: TAG_WIDTH];
  assign w_wo     = r_addr[BO_WIDTH +: WO_WIDTH];
  assign w_unused = ^r_addr;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < NWAYS; w++)
      if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = AGE_WIDTH'(w);
      end
  end

  // the way being touched is the hit way during lookup, the latched victim during refill
  assign w_way          = (r_state == S_LOOKUP) ? w_hit_way : r_way;
  assign w_blk          = (r_state == S_REFILL) ? mem_rd_blk : r_data[w_idx][w_way];
  assign w_word_old     = w_blk[w_wo*WRD_WIDTH +: WRD_WIDTH];
  assign w_victim_dirty = r_dirty[w_idx][w_victim];

  always_comb begin
    w_word_new = w_word_old;
    for (int b = 0; b < NBE; b++)
      w_word_new[b*8 +: 8] = (r_wr && r_be[b]) ? r_wdata[b*8 +: 8] : w_word_old[b*8 +: 8];
    w_blk_new = w_blk;
    w_blk_new[w_wo*WRD_WIDTH +: WRD_WIDTH] = w_word_new;
  end

  cache_assoc_wb_lru #(.NWAYS(NWAYS), .AW(AGE_WIDTH)) u_lru (
    .i_age    (r_age[w_idx]),
    .i_valid  (r_valid[w_idx]),
    .i_way    (w_way),
    .o_victim (w_victim),
    .o_age    (w_age_new)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      w_next = cpu_req_valid ? S_LOOKUP : S_IDLE;
      S_LOOKUP:    w_next = w_hit ? S_RESPOND : w_victim_dirty ? S_WRITEBACK : S_REFILL;
      S_WRITEBACK: w_next = mem_ack ? S_REFILL : S_WRITEBACK;
      S_REFILL:    w_next = mem_ack ? S_RESPOND : S_REFILL;
      default:     w_next = S_IDLE;
    endcase
    cpu_req_ready  = r_state == S_IDLE;
    cpu_resp_valid = r_state == S_RESPOND;
    cpu_resp_rdata = (r_state == S_RESPOND) ? r_rdata : '0;
    cpu_resp_hit   = (r_state == S_RESPOND) && r_hit;
    mem_req_valid  = (r_state == S_WRITEBACK) || (r_state == S_REFILL);
    mem_req_wr     = r_state == S_WRITEBACK;
    mem_req_addr   = (r_state == S_WRITEBACK) ? {r_tag[w_idx][r_way], w_idx, {(WO_WIDTH+BO_WIDTH){1'b0}}} :
                     (r_state == S_REFILL)    ? {w_tag, w_idx, {(WO_WIDTH+BO_WIDTH){1'b0}}} : '0;
    mem_req_wblk   = (r_state == S_WRITEBACK) ? r_data[w_idx][r_way] : '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      for (int s = 0; s < NSETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < NWAYS; w++) r_age[s][w] <= AGE_WIDTH'(w);
      end
    end else begin
      r_state <= w_next;
      if (r_state == S_LOOKUP && w_hit) begin
        r_age[w_idx] <= w_age_new;
        if (r_wr) r_dirty[w_idx][w_hit_way] <= 1'b1;
      end
      if (r_state == S_REFILL && mem_ack) begin
        r_age[w_idx]          <= w_age_new;
        r_valid[w_idx][r_way] <= 1'b1;
        r_dirty[w_idx][r_way] <= r_wr;
      end
    end

  // tag/data and the latched request carry no reset; outputs are gated by state instead
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && cpu_req_valid) begin
      r_addr  <= cpu_req_addr;
      r_wr    <= cpu_req_wr;
      r_wdata <= cpu_req_wdata;
      r_be    <= cpu_req_be;
    end
    if (r_state == S_LOOKUP) begin
      r_way   <= w_hit ? w_hit_way : w_victim;
      r_hit   <= w_hit;
      r_rdata <= w_word_new;
    end
    if (r_state == S_LOOKUP && w_hit && r_wr) r_data[w_idx][w_hit_way] <= w_blk_new;
    if (r_state == S_REFILL && mem_ack) begin
      r_data[w_idx][r_way] <= w_blk_new;
      r_tag[w_idx][r_way]  <= w_tag;
      r_rdata              <= w_word_new;
    end
  end
endmodule

// File: tb/tb_cache_assoc_wb.sv
// tb_cache_assoc_wb: scoreboard bench; a recency-list cache model predicts responses and memory traffic.
module tb_cache_assoc_wb;
  localparam int NW = 4, NS = 128, WPB = 16, BLK = 32 * WPB;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cpu_req_valid = 1'b0, cpu_req_wr = 1'b0;
  logic [31:0] cpu_req_addr = '0, cpu_req_wdata = '0;
  logic [3:0] cpu_req_be = '0;
  logic cpu_req_ready, cpu_resp_valid, cpu_resp_hit, mem_req_valid, mem_req_wr;
  logic [31:0] cpu_resp_rdata, mem_req_addr;
  logic [BLK-1:0] mem_req_wblk;
  logic mem_ack = 1'b0;
  logic [BLK-1:0] mem_rd_blk = '0;

  always #5 clk = ~clk;

  cache_assoc_wb dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_wr(cpu_req_wr),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_be(cpu_req_be),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_hit(cpu_resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr),
    .mem_req_wblk(mem_req_wblk), .mem_ack(mem_ack), .mem_rd_blk(mem_rd_blk)
  );

  typedef struct {logic [31:0] rdata; bit hit;} resp_t;
  typedef struct {bit wr; logic [31:0] addr; logic [BLK-1:0] blk;} mreq_t;
  resp_t exp_resp[$];
  mreq_t exp_mem[$];
  int n_cmp = 0, n_bad = 0, n_resp = 0, cyc = 0, acc_cyc = 0, ack_mode = -1;
  logic [31:0] last_rdata;
  bit last_hit;
  logic [BLK-1:0] mem [logic [31:0]];
  bit m_valid [NS][NW];
  bit m_dirty [NS][NW];
  logic [18:0] m_tag [NS][NW];
  logic [31:0] m_data [NS][NW][WPB];
  int lru [NS][NW];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [BLK-1:0] act, input logic [BLK-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // untouched memory: word k of the block at address a holds (a - 0x1040 + 0xA0) + k
  function automatic logic [BLK-1:0] mem_get(input logic [31:0] a);
    logic [BLK-1:0] b;
    if (mem.exists(a)) return mem[a];
    for (int k = 0; k < WPB; k++) b[k*32 +: 32] = a - 32'h1040 + 32'hA0 + 32'(k);
    return b;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        lru[s][w] = w;
      end
  endtask

  // lru[s] lists ways from most to least recently used
  task automatic model(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    int s = int'(a[12:6]);
    int wo = int'(a[5:2]);
    logic [18:0] t = a[31:13];
    int way = -1;
    int p = 0;
    bit hit;
    logic [BLK-1:0] b;
    mreq_t mr;
    resp_t r;
    for (int w = 0; w < NW; w++) if (m_valid[s][w] && m_tag[s][w] == t) way = w;
    hit = way >= 0;
    if (!hit) begin
      for (int w = NW - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
      if (way < 0) way = lru[s][NW-1];
      if (m_valid[s][way] && m_dirty[s][way]) begin
        for (int k = 0; k < WPB; k++) b[k*32 +: 32] = m_data[s][way][k];
        mr.wr = 1; mr.addr = {m_tag[s][way], 7'(s), 6'd0}; mr.blk = b;
        exp_mem.push_back(mr);
        mem[mr.addr] = b;
      end
      mr.wr = 0; mr.addr = {t, 7'(s), 6'd0}; mr.blk = '0;
      exp_mem.push_back(mr);
      b = mem_get(mr.addr);
      for (int k = 0; k < WPB; k++) m_data[s][way][k] = b[k*32 +: 32];
      m_valid[s][way] = 1; m_tag[s][way] = t; m_dirty[s][way] = 0;
    end
    if (wr) begin
      for (int i = 0; i < 4; i++) if (be[i]) m_data[s][way][wo][i*8 +: 8] = wd[i*8 +: 8];
      m_dirty[s][way] = 1;
    end
    r.rdata = m_data[s][way][wo]; r.hit = hit;
    exp_resp.push_back(r);
    for (int i = 0; i < NW; i++) if (lru[s][i] == way) p = i;
    for (int i = p; i > 0; i--) lru[s][i] = lru[s][i-1];
    lru[s][0] = way;
  endtask

  // after acceptance a junk request is sometimes held one cycle; the busy cache must ignore it
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be, input bit wait_resp);
    int prev = n_resp;
    int k;
    model(wr, a, wd, be);
    cpu_req_valid = 1; cpu_req_wr = wr; cpu_req_addr = a; cpu_req_wdata = wd; cpu_req_be = be;
    @(negedge clk);
    acc_cyc = cyc;
    chk("req_ready", cpu_req_ready, 1);
    @(posedge clk); #1;
    if ($urandom_range(0, 1) == 1) begin
      cpu_req_wr = 1'($urandom); cpu_req_addr = $urandom; cpu_req_wdata = $urandom; cpu_req_be = 4'($urandom);
    end else cpu_req_valid = 0;
    @(posedge clk); #1;
    cpu_req_valid = 0;
    if (!wait_resp) return;
    for (k = 0; k < 300 && n_resp == prev; k++) @(posedge clk);
    #1;
    if (n_resp == prev) begin
      n_cmp++; n_bad++;
      $display("FAIL resp_timeout: got no response expected one within 300 cycles");
    end
  endtask

  always @(negedge clk) begin
    resp_t e;
    if (rst_n && cpu_resp_valid) begin
      if (exp_resp.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_resp: got rdata %0h expected no response", cpu_resp_rdata);
      end else begin
        e = exp_resp.pop_front();
        chk("resp_rdata", cpu_resp_rdata, e.rdata);
        chk("resp_hit", cpu_resp_hit, e.hit);
        if (e.hit) chk("hit_latency", cyc - acc_cyc, 2);
      end
      last_rdata = cpu_resp_rdata;
      last_hit = cpu_resp_hit;
      n_resp++;
    end
  end

  // memory responder: checks each request, holds it d cycles checking stability, then acks
  initial begin
    mreq_t e, cap;
    int d;
    bit ab;
    @(negedge clk);
    forever begin
      if (rst_n && mem_req_valid) begin
        cap.wr = mem_req_wr; cap.addr = mem_req_addr; cap.blk = mem_req_wblk;
        if (exp_mem.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_mem_req: got addr %0h expected no request", mem_req_addr);
        end else begin
          e = exp_mem.pop_front();
          chk("mem_wr", mem_req_wr, e.wr);
          chk("mem_addr", mem_req_addr, e.addr);
          if (e.wr) chk("mem_wblk", mem_req_wblk, e.blk);
        end
        d = ack_mode >= 0 ? ack_mode : ($urandom_range(0, 3) == 0 ? 10 : $urandom_range(0, 2));
        ab = 0;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (!rst_n) begin ab = 1; break; end
          chk("mem_hold_valid", mem_req_valid, 1);
          chk("mem_hold_wr", mem_req_wr, cap.wr);
          chk("mem_hold_addr", mem_req_addr, cap.addr);
          chk("mem_hold_wblk", mem_req_wblk, cap.blk);
          chk("busy_ready_low", cpu_req_ready, 0);
        end
        if (ab) @(negedge clk);
        else begin
          mem_rd_blk = mem_get(cap.addr);
          mem_ack = 1;
          @(negedge clk);
          mem_ack = 0;
        end
      end else begin
        mem_ack = rst_n && $urandom_range(0, 7) == 0;
        @(negedge clk);
        mem_ack = 0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_outputs();
    chk("rst_ready", cpu_req_ready, 1);
    chk("rst_resp_valid", cpu_resp_valid, 0);
    chk("rst_resp_rdata", cpu_resp_rdata, 0);
    chk("rst_resp_hit", cpu_resp_hit, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_mem_wr", mem_req_wr, 0);
    chk("rst_mem_addr", mem_req_addr, 0);
    chk("rst_mem_wblk", mem_req_wblk, 0);
  endtask

  initial begin
    logic [31:0] a;
    int k;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1;
    @(posedge clk); #1;
    ack_mode = 2;
    issue(0, 32'h1040, 0, 0, 1);
    chk("first_load_rdata", last_rdata, 32'hA0);
    chk("first_load_hit", last_hit, 0);
    issue(0, 32'h1040, 0, 0, 1);
    chk("reload_hit", last_hit, 1);
    issue(1, 32'h1044, 32'hDEAD_BEEF, 4'b0011, 1);
    chk("store_rdata", last_rdata, 32'h0000_BEEF);
    chk("store_hit", last_hit, 1);
    issue(0, 32'h1044, 0, 0, 1);
    chk("load_after_store", last_rdata, 32'h0000_BEEF);
    ack_mode = 10;
    for (int n = 1; n < 4; n++) issue(0, 32'h1040 + 32'(n) * 32'h2000, 0, 0, 1);
    ack_mode = 0;
    issue(0, 32'h1040, 0, 0, 1);
    chk("set_full_hit_a", last_hit, 1);
    issue(0, 32'h9040, 0, 0, 1);
    chk("load_e_miss", last_hit, 0);
    issue(0, 32'h3040, 0, 0, 1);
    chk("evicted_b_miss", last_hit, 0);
    ack_mode = -1;
    for (int n = 5; n < 9; n++) issue(0, 32'h1040 + 32'(n) * 32'h2000, 0, 0, 1);
    for (int i = 0; i < 300; i++) begin
      a = {19'($urandom_range(0, 5)), 7'(32'h41 + $urandom_range(0, 1)), 4'($urandom), 2'($urandom)};
      issue(1'($urandom), a, $urandom, 4'($urandom), 1);
    end
    // reset in the middle of a refill abandons the transfer
    ack_mode = 1000;
    issue(0, 32'h0000_0400, 0, 0, 0);
    for (k = 0; k < 50 && !(mem_req_valid && !mem_req_wr); k++) @(posedge clk);
    #1;
    chk("reached_refill", mem_req_valid && !mem_req_wr, 1);
    rst_n = 0;
    #1;
    chk_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    exp_resp.delete();
    exp_mem.delete();
    model_reset();
    ack_mode = 2;
    rst_n = 1;
    @(posedge clk); #1;
    issue(0, 32'h1040, 0, 0, 1);
    chk("post_reset_miss", last_hit, 0);
    issue(0, 32'h1040, 0, 0, 1);
    chk("post_reset_rehit", last_hit, 1);
    repeat (5) @(posedge clk);
    chk("resp_queue_drained", exp_resp.size(), 0);
    chk("mem_queue_drained", exp_mem.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
